dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Holds the responder FSM state encoding, data word width and latency counter width.
// Imported by dmem_responder and dmem_array.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM backing the data-memory responder.
// Latency: write lands at the strobed edge; read data is registered at the strobed edge.
// Backpressure: none; rdata holds its value until the next read strobe.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [WORD_W-1:0] rdata_q;

  // One access per strobe: store writes the array, load captures the word
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= wdata;
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, one-cycle response pulse out.
// Latency: response pulse LATENCY cycles after acceptance; one transaction per LATENCY+1 cycles.
// Backpressure: req_ready low (busy high) from acceptance through the response cycle; no queuing.
// Optional build macro DMEM_ALIGN_CHECK_EN adds rsp_err and suppresses misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              busy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              rsp_err
`endif
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  localparam bit             LAT_ONE  = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;
  logic                    mis_q, mis_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rd_sel_q, rd_sel_d;

  logic                    accept;
  logic                    enter_resp;
  logic                    op_wr;
  logic                    op_mis;
  logic [DEPTH_LOG2-1:0]   op_idx;
  logic [WORD_W-1:0]       op_wdata;
  logic                    ram_en;
  logic [WORD_W-1:0]       ram_rdata;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  assign accept = (state_q == IDLE) && req_valid;

  // Operation fields: live request on the accept edge (LATENCY==1), latched copy otherwise
  assign op_wr    = accept ? req_write : wr_q;
  assign op_idx   = accept ? req_addr[DEPTH_LOG2+1:2] : idx_q;
  assign op_wdata = accept ? req_wdata : wdata_q;
  assign op_mis   = accept ? (ALIGN_EN && (req_addr[1:0] != 2'b00)) : mis_q;

  // Next-state, counter and response-register computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    mis_d       = mis_q;
    rsp_valid_d = 1'b0;
    rd_sel_d    = rd_sel_q;
    enter_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          idx_d   = req_addr[DEPTH_LOG2+1:2];
          wdata_d = req_wdata;
          mis_d   = ALIGN_EN && (req_addr[1:0] != 2'b00);
          cnt_d   = CNT_INIT;
          if (LAT_ONE) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 4'd1) begin
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (enter_resp) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rd_sel_d    = !op_wr && !op_mis;
    end
  end

  // Storage is touched only on the edge entering RESP, never while reset is asserted
  assign ram_en = enter_resp && !op_mis && rst_n;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (op_wr),
    .idx  (op_idx),
    .wdata(op_wdata),
    .rdata(ram_rdata)
  );

  // FSM state, counter, latched request and registered response flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mis_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      mis_q       <= mis_d;
      rsp_valid_q <= rsp_valid_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  // Stores and suppressed accesses report zero; a load keeps the RAM word until the next response
  assign rsp_rdata = rd_sel_q ? ram_rdata : '0;
`ifdef DMEM_ALIGN_CHECK_EN
  assign rsp_err   = rsp_valid_q && mis_q;
`endif

endmodule
